// File: rtl/datamem_copy_engine.sv
// -----------------------------------------------------------------------------
// datamem_copy_engine
//
// Bus-master DMA engine for the 16-bit word-addressed data-memory port.
// Copies i_length words from i_src_addr to i_dst_addr, one word every two
// cycles (READ then WRITE). It relies on the memory's combinational read and
// posedge write, and is meant to sit beside the core, muxed onto the memory
// port.
//
// Ports
//   clk                in   clock, all state changes on posedge
//   reset              in   synchronous, active-high reset
//   i_start            in   transfer request, sampled only in IDLE
//   i_src_addr         in   first source word address
//   i_dst_addr         in   first destination word address
//   i_length           in   number of words to copy (0 is legal)
//   o_busy             out  1 whenever the engine is not IDLE
//   o_done             out  1-cycle pulse when a transfer completes
//   o_words_done       out  words written in the current/last transfer
//   o_mem_address      out  memory word address
//   o_mem_read_enable  out  memory read enable
//   o_mem_write_enable out  memory write enable
//   o_mem_write_data   out  memory write data
//   i_mem_read_data    in   memory read data (combinational, same cycle)
//   o_checksum         out  modulo-2^16 sum of written words
//                           (present only when DMA_CHECKSUM_EN is defined)
//
// Configuration macro: DMA_CHECKSUM_EN enables the checksum port and its
// accumulator. Without it the engine is otherwise identical.
// -----------------------------------------------------------------------------
module datamem_copy_engine #(
  parameter int ADDR_W = 16,
  parameter int DATA_W = 16,
  parameter int LEN_W  = 16
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              i_start,
  input  logic [ADDR_W-1:0] i_src_addr,
  input  logic [ADDR_W-1:0] i_dst_addr,
  input  logic [LEN_W-1:0]  i_length,
  output logic              o_busy,
  output logic              o_done,
  output logic [LEN_W-1:0]  o_words_done,
  output logic [ADDR_W-1:0] o_mem_address,
  output logic              o_mem_read_enable,
  output logic              o_mem_write_enable,
  output logic [DATA_W-1:0] o_mem_write_data,
`ifdef DMA_CHECKSUM_EN
  output logic [DATA_W-1:0] o_checksum,
`endif
  input  logic [DATA_W-1:0] i_mem_read_data
);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_READ  = 2'd1,
    S_WRITE = 2'd2,
    S_DONE  = 2'd3
  } state_t;

  state_t            r_state;
  state_t            w_state_next;

  logic [ADDR_W-1:0] r_src;
  logic [ADDR_W-1:0] r_dst;
  logic [LEN_W-1:0]  r_len;
  logic [LEN_W-1:0]  r_idx;
  logic [DATA_W-1:0] r_buf;
  logic [LEN_W-1:0]  r_words_done;

  logic [LEN_W-1:0]  w_idx_inc;
  logic [ADDR_W-1:0] w_offset;
  logic              w_accept;

  assign w_idx_inc = r_idx + 1'b1;
  // Address offset is truncated/extended to the address width so src+i and
  // dst+i wrap modulo 2^ADDR_W.
  assign w_offset  = ADDR_W'(r_idx);
  assign w_accept  = (r_state == S_IDLE) && i_start;

  // Control state: FSM, word index and progress counter.
  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values, independent of statement order.
    if (reset) begin
      r_state      <= S_IDLE;
      r_idx        <= '0;
      r_words_done <= '0;
    end else begin
      r_state <= w_state_next;
      if (w_accept) begin
        r_idx        <= '0;
        r_words_done <= '0;
      end else if (r_state == S_WRITE) begin
        r_idx        <= w_idx_inc;
        r_words_done <= w_idx_inc;
      end
    end
  end

  // Datapath registers.
  // NOTE: these are only consumed after being loaded (on an accepted start or
  // in READ), so they carry no reset; that keeps reset fan-out to control.
  always_ff @(posedge clk) begin
    if (w_accept) begin
      r_src <= i_src_addr;
      r_dst <= i_dst_addr;
      r_len <= i_length;
    end
    if (r_state == S_READ) begin
      r_buf <= i_mem_read_data;
    end
  end

`ifdef DMA_CHECKSUM_EN
  logic [DATA_W-1:0] r_checksum;

  always_ff @(posedge clk) begin
    if (reset) begin
      r_checksum <= '0;
    end else if (w_accept) begin
      r_checksum <= '0;
    end else if (r_state == S_WRITE) begin
      r_checksum <= r_checksum + r_buf;
    end
  end

  assign o_checksum = r_checksum;
`endif

  // Next-state and memory-port outputs.
  always_comb begin
    // NOTE: every output gets a default first so no path leaves one unassigned,
    // which would otherwise infer a latch.
    w_state_next       = r_state;
    o_mem_address      = '0;
    o_mem_read_enable  = 1'b0;
    o_mem_write_enable = 1'b0;
    o_mem_write_data   = '0;
    unique case (r_state)
      S_IDLE: begin
        if (i_start) begin
          w_state_next = (i_length == '0) ? S_DONE : S_READ;
        end
      end
      S_READ: begin
        o_mem_read_enable = 1'b1;
        o_mem_address     = r_src + w_offset;
        w_state_next      = S_WRITE;
      end
      S_WRITE: begin
        o_mem_write_enable = 1'b1;
        o_mem_address      = r_dst + w_offset;
        o_mem_write_data   = r_buf;
        w_state_next       = (w_idx_inc == r_len) ? S_DONE : S_READ;
      end
      S_DONE: begin
        w_state_next = S_IDLE;
      end
      default: w_state_next = S_IDLE;
    endcase
  end

  assign o_busy       = (r_state != S_IDLE);
  assign o_done       = (r_state == S_DONE);
  assign o_words_done = r_words_done;

endmodule

// File: tb/tb_datamem_copy_engine.sv
// -----------------------------------------------------------------------------
// tb_datamem_copy_engine
//
// Directed bench for datamem_copy_engine. A behavioural 64K x 16 memory with
// combinational read and posedge write sits on the engine's memory port; the
// bench preloads it through a private write port on the same process.
// Checksum expectations are compared only when DMA_CHECKSUM_EN is defined.
// -----------------------------------------------------------------------------
module tb_datamem_copy_engine;

  logic        clk;
  logic        reset;
  logic        i_start;
  logic [15:0] i_src_addr;
  logic [15:0] i_dst_addr;
  logic [15:0] i_length;
  logic        o_busy;
  logic        o_done;
  logic [15:0] o_words_done;
  logic [15:0] o_mem_address;
  logic        o_mem_read_enable;
  logic        o_mem_write_enable;
  logic [15:0] o_mem_write_data;
  logic [15:0] i_mem_read_data;
`ifdef DMA_CHECKSUM_EN
  logic [15:0] o_checksum;
`endif

  int checks = 0;
  int errors = 0;

  datamem_copy_engine #(.ADDR_W(16), .DATA_W(16), .LEN_W(16)) dut (
    .clk                (clk),
    .reset              (reset),
    .i_start            (i_start),
    .i_src_addr         (i_src_addr),
    .i_dst_addr         (i_dst_addr),
    .i_length           (i_length),
    .o_busy             (o_busy),
    .o_done             (o_done),
    .o_words_done       (o_words_done),
    .o_mem_address      (o_mem_address),
    .o_mem_read_enable  (o_mem_read_enable),
    .o_mem_write_enable (o_mem_write_enable),
    .o_mem_write_data   (o_mem_write_data),
`ifdef DMA_CHECKSUM_EN
    .o_checksum         (o_checksum),
`endif
    .i_mem_read_data    (i_mem_read_data)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Memory model: one writer process for both the DUT and the preload port.
  logic [15:0] mem [0:65535];
  logic        tb_wr_en = 1'b0;
  logic [15:0] tb_wr_addr = '0;
  logic [15:0] tb_wr_data = '0;

  always @(posedge clk) begin
    if (o_mem_write_enable) mem[o_mem_address] <= o_mem_write_data;
    else if (tb_wr_en)      mem[tb_wr_addr]    <= tb_wr_data;
  end

  assign i_mem_read_data = mem[o_mem_address];

  // Activity monitors sampled mid-cycle.
  int en_cycles   = 0;
  int both_cycles = 0;
  int done_pulses = 0;
  always @(negedge clk) begin
    if (o_mem_read_enable || o_mem_write_enable) en_cycles++;
    if (o_mem_read_enable && o_mem_write_enable) both_cycles++;
    if (o_done) done_pulses++;
  end

  task automatic poke(input logic [15:0] addr, input logic [15:0] data);
    @(negedge clk);
    tb_wr_en   = 1'b1;
    tb_wr_addr = addr;
    tb_wr_data = data;
    @(posedge clk);
    #1 tb_wr_en = 1'b0;
  endtask

  // Present a start at a negedge; it is sampled on the following posedge.
  task automatic issue_start(input logic [15:0] src, input logic [15:0] dst,
                             input logic [15:0] len);
    @(negedge clk);
    i_src_addr = src;
    i_dst_addr = dst;
    i_length   = len;
    i_start    = 1'b1;
    @(posedge clk);
    #1 i_start = 1'b0;
  endtask

  // Returns the cycle index (1 = cycle right after the start edge) in which
  // done is seen, or -1 if it never appears within the budget.
  task automatic wait_done(input int budget, output int idx);
    idx = -1;
    for (int c = 1; c <= budget; c++) begin
      @(negedge clk);
      if (o_done) begin
        idx = c;
        break;
      end
    end
  endtask

  task automatic expect_val(input string name, input logic [15:0] act,
                            input logic [15:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%04h, expected 0x%04h", name, act, exp);
    end
  endtask

  task automatic expect_idle(input string name);
    expect_val({name, " busy"},  {15'd0, o_busy}, 16'd0);
    expect_val({name, " done"},  {15'd0, o_done}, 16'd0);
    expect_val({name, " rd_en"}, {15'd0, o_mem_read_enable}, 16'd0);
    expect_val({name, " wr_en"}, {15'd0, o_mem_write_enable}, 16'd0);
    expect_val({name, " addr"},  o_mem_address, 16'd0);
    expect_val({name, " wdata"}, o_mem_write_data, 16'd0);
  endtask

  task automatic test_reset();
    reset = 1'b1;
    repeat (2) @(posedge clk);
    #1 reset = 1'b0;
    repeat (5) @(negedge clk);
    expect_idle("reset");
    expect_val("reset words_done", o_words_done, 16'd0);
`ifdef DMA_CHECKSUM_EN
    expect_val("reset checksum", o_checksum, 16'd0);
`endif
  endtask

  task automatic test_basic_copy();
    logic [15:0] exp [4];
    int idx;
    exp = '{16'h1111, 16'h2222, 16'h3333, 16'h4444};
    for (int j = 0; j < 4; j++) poke(16'h0010 + 16'(j), exp[j]);
    issue_start(16'h0010, 16'h0040, 16'd4);
    wait_done(40, idx);
    expect_val("basic done cycle", 16'(idx), 16'd9);
    expect_val("basic busy in done", {15'd0, o_busy}, 16'd1);
    for (int j = 0; j < 4; j++)
      expect_val("basic dst word", mem[16'h0040 + 16'(j)], exp[j]);
    expect_val("basic words_done", o_words_done, 16'd4);
`ifdef DMA_CHECKSUM_EN
    expect_val("basic checksum", o_checksum, 16'hAAAA);
`endif
    @(negedge clk);
    expect_idle("basic after done");
    expect_val("basic words_done held", o_words_done, 16'd4);
  endtask

  task automatic test_zero_length();
    int idx;
    int en_before;
    en_before = en_cycles;
    issue_start(16'h0010, 16'h0080, 16'd0);
    wait_done(10, idx);
    expect_val("zero done cycle", 16'(idx), 16'd1);
    expect_val("zero busy in done", {15'd0, o_busy}, 16'd1);
    @(negedge clk);
    expect_val("zero busy after", {15'd0, o_busy}, 16'd0);
    expect_val("zero words_done", o_words_done, 16'd0);
    expect_val("zero enables", 16'(en_cycles - en_before), 16'd0);
`ifdef DMA_CHECKSUM_EN
    expect_val("zero checksum", o_checksum, 16'd0);
`endif
  endtask

  task automatic test_wrap();
    int idx;
    poke(16'hFFFE, 16'h000A);
    poke(16'hFFFF, 16'h000B);
    poke(16'h0000, 16'h000C);
    issue_start(16'hFFFE, 16'h0100, 16'd3);
    wait_done(40, idx);
    expect_val("wrap done cycle", 16'(idx), 16'd7);
    expect_val("wrap dst0", mem[16'h0100], 16'h000A);
    expect_val("wrap dst1", mem[16'h0101], 16'h000B);
    expect_val("wrap dst2", mem[16'h0102], 16'h000C);
    expect_val("wrap words_done", o_words_done, 16'd3);
`ifdef DMA_CHECKSUM_EN
    expect_val("wrap checksum", o_checksum, 16'h0021);
`endif
  endtask

  task automatic test_start_ignored();
    int pulses_before;
    poke(16'h0300, 16'hDEAD);
    pulses_before = done_pulses;
    issue_start(16'h0010, 16'h0200, 16'd4);
    @(negedge clk);
    // Second cycle of the transfer: pulse start with different arguments.
    i_src_addr = 16'h0020;
    i_dst_addr = 16'h0300;
    i_length   = 16'd2;
    i_start    = 1'b1;
    @(posedge clk);
    #1 i_start = 1'b0;
    repeat (20) @(negedge clk);
    expect_val("ignore done pulses", 16'(done_pulses - pulses_before), 16'd1);
    expect_val("ignore dst0", mem[16'h0200], 16'h1111);
    expect_val("ignore dst3", mem[16'h0203], 16'h4444);
    expect_val("ignore other dst", mem[16'h0300], 16'hDEAD);
    expect_val("ignore words_done", o_words_done, 16'd4);
  endtask

  task automatic test_reset_abort();
    int idx;
    int pulses_before;
    for (int j = 0; j < 8; j++) poke(16'h0050 + 16'(j), 16'h5000 + 16'(j));
    pulses_before = done_pulses;
    issue_start(16'h0050, 16'h0500, 16'd8);
    repeat (6) @(negedge clk);
    expect_val("abort in write3", {15'd0, o_mem_write_enable}, 16'd1);
    expect_val("abort write3 addr", o_mem_address, 16'h0502);
    reset = 1'b1;
    @(posedge clk);
    #1 reset = 1'b0;
    @(negedge clk);
    expect_idle("abort");
    expect_val("abort words_done", o_words_done, 16'd0);
    repeat (4) @(negedge clk);
    expect_val("abort no done", 16'(done_pulses - pulses_before), 16'd0);
    expect_val("abort kept dst0", mem[16'h0500], 16'h5000);
    expect_val("abort kept dst1", mem[16'h0501], 16'h5001);
    issue_start(16'h0057, 16'h0600, 16'd1);
    wait_done(20, idx);
    expect_val("abort restart done cycle", 16'(idx), 16'd3);
    expect_val("abort restart dst", mem[16'h0600], 16'h5007);
    expect_val("abort restart words_done", o_words_done, 16'd1);
  endtask

  task automatic test_back_to_back();
    int idx;
    issue_start(16'h0011, 16'h0700, 16'd2);
    wait_done(20, idx);
    expect_val("b2b first done cycle", 16'(idx), 16'd5);
    // Start presented in the IDLE cycle directly after DONE.
    issue_start(16'h0013, 16'h0710, 16'd1);
    wait_done(20, idx);
    expect_val("b2b second done cycle", 16'(idx), 16'd3);
    expect_val("b2b first dst0", mem[16'h0700], 16'h2222);
    expect_val("b2b first dst1", mem[16'h0701], 16'h3333);
    expect_val("b2b second dst", mem[16'h0710], 16'h4444);
`ifdef DMA_CHECKSUM_EN
    expect_val("b2b checksum", o_checksum, 16'h4444);
`endif
  endtask

  initial begin
    for (int a = 0; a < 65536; a++) mem[a] = '0;
    reset      = 1'b1;
    i_start    = 1'b0;
    i_src_addr = '0;
    i_dst_addr = '0;
    i_length   = '0;

    test_reset();
    test_basic_copy();
    test_zero_length();
    test_wrap();
    test_start_ignored();
    test_reset_abort();
    test_back_to_back();
    expect_val("never both enables", 16'(both_cycles), 16'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
